// File: rtl/lut_ff_mux_bist_seq_pkg.sv
// Shared types and constants for the lut_ff_mux self-test sequencer.
// Holds the FSM encoding, the directed vector table and the LFSR step function.
package lut_ff_mux_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_COMPARE,
        ST_NEXT,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    typedef struct packed {
        logic       dut_rst;
        logic [3:0] din;
        logic       sel;
    } stim_t;

    localparam int          NUM_DIRECTED = 5;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    localparam logic [3:0] DIR_IN_1  = 4'b0100;
    localparam logic [3:0] DIR_IN_2  = 4'b0100;
    localparam logic [3:0] DIR_IN_3  = 4'b0001;
    localparam logic [3:0] DIR_IN_4  = 4'b0001;
    localparam logic       DIR_SEL_1 = 1'b0;
    localparam logic       DIR_SEL_2 = 1'b1;
    localparam logic       DIR_SEL_3 = 1'b0;
    localparam logic       DIR_SEL_4 = 1'b1;

    // Vector 0 holds the DUT in reset; vectors 1..4 exercise both mux legs.
    function automatic stim_t directed_vec(input logic [2:0] idx);
        stim_t v;
        v = '{dut_rst: 1'b1, din: 4'h0, sel: 1'b0};
        case (idx)
            3'd1: v = '{dut_rst: 1'b0, din: DIR_IN_1, sel: DIR_SEL_1};
            3'd2: v = '{dut_rst: 1'b0, din: DIR_IN_2, sel: DIR_SEL_2};
            3'd3: v = '{dut_rst: 1'b0, din: DIR_IN_3, sel: DIR_SEL_3};
            3'd4: v = '{dut_rst: 1'b0, din: DIR_IN_4, sel: DIR_SEL_4};
            default: v = '{dut_rst: 1'b1, din: 4'h0, sel: 1'b0};
        endcase
        return v;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lut_ff_mux_bist_seq_if.sv
// Bundle between the self-test sequencer and the test wrapper around lut_ff_mux.
// master = sequencer side, slave = wrapper/environment side.
interface lut_ff_mux_bist_seq_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [3:0]       stim_in;
    logic             stim_mux_sel;
    logic             stim_rst;
    logic             q_golden;
    logic             q_netlist;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [15:0]      vec_idx;

    modport master (
        input  start, q_golden, q_netlist,
        output stim_in, stim_mux_sel, stim_rst,
        output busy, done, pass, mismatch_cnt, vec_idx
    );

    modport slave (
        output start, q_golden, q_netlist,
        input  stim_in, stim_mux_sel, stim_rst,
        input  busy, done, pass, mismatch_cnt, vec_idx
    );
endinterface

// File: rtl/lut_ff_mux_bist_seq_lfsr.sv
// 16-bit right-shifting Galois LFSR used for the random phase of the self-test.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module bist_lfsr16
    import lut_ff_mux_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] state
);
    localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SAFE_SEED;
        end else if (load) begin
            state <= SAFE_SEED;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end
endmodule

// File: rtl/lut_ff_mux_bist.sv
// Self-test sequencer for lut_ff_mux: directed then LFSR vectors, golden vs netlist
// compare with a saturating mismatch counter and a pass/fail verdict.
module lut_ff_mux_bist_seq
    import lut_ff_mux_bist_pkg::*;
#(
    parameter int          NUM_RANDOM    = 100,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          SETTLE_CYCLES = 1,
    parameter int          DRAIN_CYCLES  = 5,
    parameter int          CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    lut_ff_mux_bist_seq_if.master bus
);
    localparam logic [16:0] LAST_IDX   = 17'(NUM_DIRECTED - 1 + NUM_RANDOM);
    localparam logic [16:0] LAST_DIR   = 17'(NUM_DIRECTED - 1);
    localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DRAIN_END  = 16'(DRAIN_CYCLES - 1);

    bist_state_t      state;
    bist_state_t      state_nx;
    logic [15:0]      timer;
    logic [16:0]      idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       stim_in;
    logic             stim_mux_sel;
    logic             stim_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic             accept;
    logic             lfsr_adv;
    logic             last_vec;
    logic [15:0]      lfsr_state;
    stim_t            dir_vec;

    assign last_vec = (idx == LAST_IDX);
    assign dir_vec  = directed_vec(idx[2:0]);

    bist_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .advance(lfsr_adv),
        .state  (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        lfsr_adv = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = ST_APPLY;
                end
            end
            ST_APPLY:   state_nx = ST_SETTLE;
            ST_SETTLE:  if (timer == SETTLE_END) state_nx = ST_COMPARE;
            ST_COMPARE: state_nx = ST_NEXT;
            ST_NEXT: begin
                if (last_vec) begin
                    state_nx = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    state_nx = ST_APPLY;
                    lfsr_adv = (idx >= LAST_DIR);
                end
            end
            ST_DRAIN:   if (timer == DRAIN_END) state_nx = ST_DONE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // The timer restarts on every state change so SETTLE and DRAIN count from zero.
    always_ff @(posedge clk) begin
        if (!rst || (state != state_nx)) begin
            timer <= '0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stim_in      <= 4'h0;
            stim_mux_sel <= 1'b0;
            stim_rst     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        cnt  <= '0;
                        idx  <= '0;
                        busy <= 1'b1;
                        done <= 1'b0;
                        pass <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (idx <= LAST_DIR) begin
                        stim_rst     <= dir_vec.dut_rst;
                        stim_in      <= dir_vec.din;
                        stim_mux_sel <= dir_vec.sel;
                    end else begin
                        stim_rst     <= 1'b0;
                        stim_in      <= lfsr_state[3:0];
                        stim_mux_sel <= lfsr_state[4];
                    end
                end
                ST_COMPARE: begin
                    if ((bus.q_golden != bus.q_netlist) && !(&cnt)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (!last_vec) begin
                        idx <= idx + 17'd1;
                    end
                end
                default: ;
            endcase

            // The final count is settled by the time DONE is entered.
            if ((state_nx == ST_DONE) && (state != ST_DONE)) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (cnt == '0);
            end
        end
    end

    assign bus.stim_in      = stim_in;
    assign bus.stim_mux_sel = stim_mux_sel;
    assign bus.stim_rst     = stim_rst;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.pass         = pass;
    assign bus.mismatch_cnt = cnt;
    assign bus.vec_idx      = idx[15:0];
endmodule

// File: tb/tb_lut_ff_mux_bist_seq.sv
// Directed bench for lut_ff_mux_bist_seq: a default instance plus a small
// instance with zero seed, 4-bit counter and always-mismatching netlist.
module tb_lut_ff_mux_bist_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bad = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lut_ff_mux_bist_seq_if #(.CNT_W(16)) bus_a ();
    lut_ff_mux_bist_seq_if #(.CNT_W(4))  bus_b ();

    // Stand-in for lut_ff_mux: Q follows in[2] or in[0] depending on mux_sel.
    assign bus_a.q_golden  = bus_a.stim_mux_sel ? bus_a.stim_in[2] : bus_a.stim_in[0];
    assign bus_a.q_netlist = bad ? ~bus_a.q_golden : bus_a.q_golden;
    assign bus_b.q_golden  = bus_b.stim_mux_sel ? bus_b.stim_in[2] : bus_b.stim_in[0];
    assign bus_b.q_netlist = ~bus_b.q_golden;

    lut_ff_mux_bist_seq #(
        .NUM_RANDOM(100), .LFSR_SEED(16'hACE1), .SETTLE_CYCLES(1),
        .DRAIN_CYCLES(5), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_a.master)
    );

    lut_ff_mux_bist_seq #(
        .NUM_RANDOM(20), .LFSR_SEED(16'h0000), .SETTLE_CYCLES(2),
        .DRAIN_CYCLES(5), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Raise start for exactly one sampling edge; cyc becomes 0 at the accepting edge.
    task automatic apply_stimulus(input logic pulse_a, input logic pulse_b);
        bus_a.start = pulse_a;
        bus_b.start = pulse_b;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        cyc = 0;
    endtask

    task automatic check_stim_a(input string tag, input logic r, input logic [3:0] din, input logic sel);
        check_output({tag, "_rst"}, 32'(bus_a.stim_rst), 32'(r));
        check_output({tag, "_in"},  32'(bus_a.stim_in),  32'(din));
        check_output({tag, "_sel"}, 32'(bus_a.stim_mux_sel), 32'(sel));
    endtask

    task automatic check_stim_b(input string tag, input logic [3:0] din, input logic sel);
        check_output({tag, "_rst"}, 32'(bus_b.stim_rst), 32'd0);
        check_output({tag, "_in"},  32'(bus_b.stim_in),  32'(din));
        check_output({tag, "_sel"}, 32'(bus_b.stim_mux_sel), 32'(sel));
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        // Reset held low, then released with no start: idle values must hold.
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        check_output("idle_stim_rst", 32'(bus_a.stim_rst), 32'd1);
        check_output("idle_stim_in",  32'(bus_a.stim_in), 32'd0);
        check_output("idle_busy",     32'(bus_a.busy), 32'd0);
        check_output("idle_done",     32'(bus_a.done), 32'd0);
        check_output("idle_pass",     32'(bus_a.pass), 32'd0);
        check_output("idle_cnt",      32'(bus_a.mismatch_cnt), 32'd0);
        check_output("idle_vec_idx",  32'(bus_a.vec_idx), 32'd0);
        check_output("idle_b_cnt",    32'(bus_b.mismatch_cnt), 32'd0);

        // Clean run on both instances.
        apply_stimulus(1'b1, 1'b1);
        check_output("run1_busy_start", 32'(bus_a.busy), 32'd1);
        run_to(2);  check_stim_a("v0", 1'b1, 4'h0, 1'b0);
        run_to(6);  check_stim_a("v1", 1'b0, 4'b0100, 1'b0);
        run_to(10); check_stim_a("v2", 1'b0, 4'b0100, 1'b1);
        run_to(14); check_stim_a("v3", 1'b0, 4'b0001, 1'b0);
        run_to(18); check_stim_a("v4", 1'b0, 4'b0001, 1'b1);
        run_to(22); check_stim_a("v5", 1'b0, 4'h0, 1'b1);
        run_to(26); check_stim_a("v6", 1'b0, 4'h8, 1'b1);
        run_to(30); check_stim_a("v7", 1'b0, 4'hC, 1'b1);
        check_output("v7_idx", 32'(bus_a.vec_idx), 32'd7);

        // Zero-seed instance: LFSR walks from 16'h0001 and leaves the all-zero region.
        run_to(72); check_stim_b("b_v14", 4'hA, 1'b1);
        run_to(77); check_stim_b("b_v15", 4'hD, 1'b0);
        check_output("b_v15_idx", 32'(bus_b.vec_idx), 32'd15);
        run_to(82); check_stim_b("b_v16", 4'h6, 1'b1);
        run_to(129);
        check_output("b_done_early", 32'(bus_b.done), 32'd0);
        run_to(130);
        check_output("b_done",      32'(bus_b.done), 32'd1);
        check_output("b_cnt_sat",   32'(bus_b.mismatch_cnt), 32'd15);
        check_output("b_pass",      32'(bus_b.pass), 32'd0);

        run_to(424);
        check_output("run1_done_early", 32'(bus_a.done), 32'd0);
        check_output("run1_busy_late",  32'(bus_a.busy), 32'd1);
        run_to(425);
        check_output("run1_done", 32'(bus_a.done), 32'd1);
        check_output("run1_busy", 32'(bus_a.busy), 32'd0);
        check_output("run1_pass", 32'(bus_a.pass), 32'd1);
        check_output("run1_cnt",  32'(bus_a.mismatch_cnt), 32'd0);

        // Restart from DONE with a netlist that always disagrees.
        bad = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        check_output("run2_done_clear", 32'(bus_a.done), 32'd0);
        check_output("run2_busy",       32'(bus_a.busy), 32'd1);
        run_to(200);
        apply_stimulus(1'b1, 1'b0);
        cyc = 201;
        run_to(202);
        check_output("busy_start_idx", 32'(bus_a.vec_idx), 32'd50);
        check_output("busy_start_cnt", 32'(bus_a.mismatch_cnt), 32'd50);
        run_to(424);
        check_output("run2_done_early", 32'(bus_a.done), 32'd0);
        run_to(425);
        check_output("run2_done", 32'(bus_a.done), 32'd1);
        check_output("run2_cnt",  32'(bus_a.mismatch_cnt), 32'd105);
        check_output("run2_pass", 32'(bus_a.pass), 32'd0);

        // Reset in the middle of a run at vector 50.
        apply_stimulus(1'b1, 1'b0);
        run_to(200);
        check_output("mid_idx", 32'(bus_a.vec_idx), 32'd50);
        rst = 1'b0;
        tick();
        check_output("mid_rst_busy",     32'(bus_a.busy), 32'd0);
        check_output("mid_rst_stim_rst", 32'(bus_a.stim_rst), 32'd1);
        check_output("mid_rst_stim_in",  32'(bus_a.stim_in), 32'd0);
        check_output("mid_rst_cnt",      32'(bus_a.mismatch_cnt), 32'd0);
        check_output("mid_rst_idx",      32'(bus_a.vec_idx), 32'd0);
        rst = 1'b1;
        repeat (5) tick();
        check_output("post_rst_busy", 32'(bus_a.busy), 32'd0);
        check_output("post_rst_done", 32'(bus_a.done), 32'd0);

        // Fresh run after reset with a matching netlist.
        bad = 1'b0;
        apply_stimulus(1'b1, 1'b0);
        run_to(2);
        check_stim_a("rerun_v0", 1'b1, 4'h0, 1'b0);
        check_output("rerun_cnt", 32'(bus_a.mismatch_cnt), 32'd0);
        run_to(6);
        check_stim_a("rerun_v1", 1'b0, 4'b0100, 1'b0);
        run_to(425);
        check_output("rerun_done", 32'(bus_a.done), 32'd1);
        check_output("rerun_pass", 32'(bus_a.pass), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
